bcd_convert_sequencer: RTL and testbench

//  Multi-cycle, handshaked binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.

---
 rtl/bcd_convert_sequencer.sv | 106 ++++++++++
 tb/tb_bcd_convert_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_sequencer.sv
// Handshaked binary-to-BCD converter, one double-dabble step per clock.
// Latency: out_valid rises WIDTH cycles after the accepting edge; one result per WIDTH+2 cycles.
// Backpressure: result and overflow held in DONE until out_ready; in_ready is a pure state decode.
module bcd_convert_sequencer #(
   parameter int WIDTH  = 20,
   parameter int DIGITS = 6
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    bin_in,
   input  logic                sign_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS:0]   bcd_out,
   output logic                overflow
);

   localparam int              DW     = 4 * DIGITS;
   localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [63:0]     MAXVAL = 64'(10 ** DIGITS) - 64'd1;
   localparam logic [DW-1:0]   SAT    = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  shreg;
   logic [DW-1:0]     digits;
   logic [DW-1:0]     digit_adj;
   logic [DW-1:0]     digit_shf;
   logic [CW-1:0]     cnt;
   logic              sign_r;

   // State register; an illegal encoding is steered back to IDLE by the decode below.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state and handshake decode; handshake outputs depend only on state.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to each digit >= 5 (mod 16, no inter-digit carry), then shift in the next bit.
   always_comb begin
      digit_adj = digits;
      for (int i = 0; i < DIGITS; i++) begin
         if (digits[4*i +: 4] >= 4'd5) digit_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      end
      digit_shf = {digit_adj[DW-2:0], shreg[WIDTH-1]};
   end

   // Datapath: latch on accept, step during SHIFT, capture the (possibly saturated) result on the last step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg    <= '0;
         digits   <= '0;
         cnt      <= '0;
         sign_r   <= 1'b0;
         overflow <= 1'b0;
         bcd_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= bin_in;
                  digits   <= '0;
                  sign_r   <= sign_in;
                  overflow <= (64'(bin_in) > MAXVAL);
                  cnt      <= CW'(WIDTH - 1);
               end
            end
            SHIFT: begin
               shreg  <= shreg << 1;
               digits <= digit_shf;
               cnt    <= cnt - CW'(1);
               if (cnt == '0) bcd_out <= {sign_r, (overflow ? SAT : digit_shf)};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Self-checking bench for bcd_convert_sequencer: vector table, corner sequences, random vs reference model.
module tb_bcd_convert_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [19:0] bin_in = '0;
   logic        sign_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [24:0] bcd_out;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   bcd_convert_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .sign_in   (sign_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] bin;
      logic        sign;
      logic [24:0] bcd;
      logic        ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits by repeated division, saturated above 999999.
   function automatic logic [24:0] model_bcd(input logic [19:0] v, input logic s);
      int unsigned n = v;
      logic [23:0] d = '0;
      if (n > 999999) d = 24'h999999;
      else begin
         for (int i = 0; i < 6; i++) begin
            d[4*i +: 4] = 4'(n % 10);
            n = n / 10;
         end
      end
      return {s, d};
   endfunction

   // Full transaction: accept, measure latency, hold under backpressure, release.
   task automatic run_one(input logic [19:0] v, input logic s, input int hold,
                          output logic [24:0] res, output logic ovf, output int lat);
      int w = 0;
      logic stable = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("accept_ready", in_ready, 1);
      in_valid = 1'b1;
      bin_in   = v;
      sign_in  = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      bin_in   = 20'(~v);
      sign_in  = ~s;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("done_reached", out_valid, 1);
      res = bcd_out;
      ovf = overflow;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         if (bcd_out !== res || overflow !== ovf || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
      end
      if (hold > 0) check("hold_stable", stable, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
   endtask

   initial begin
      vec_t        tbl[8];
      logic [24:0] res;
      logic        ovf;
      int          lat;
      int          acc[$];
      int          cyc;

      tbl[0] = '{20'd0,       1'b0, 25'h0000000, 1'b0};
      tbl[1] = '{20'd998001,  1'b1, 25'h1998001, 1'b0};
      tbl[2] = '{20'd999999,  1'b0, 25'h0999999, 1'b0};
      tbl[3] = '{20'd1000000, 1'b1, 25'h1999999, 1'b1};
      tbl[4] = '{20'hFFFFF,   1'b0, 25'h0999999, 1'b1};
      tbl[5] = '{20'd0,       1'b1, 25'h1000000, 1'b0};
      tbl[6] = '{20'd1,       1'b0, 25'h0000001, 1'b0};
      tbl[7] = '{20'd509,     1'b0, 25'h0000509, 1'b0};

      // Reset state, during and after reset.
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_bcd", bcd_out, 0);
      check("rst_ovf", overflow, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_bcd", bcd_out, 0);

      // Table vectors; entry 2 also exercises a 10-cycle backpressure hold.
      for (int i = 0; i < 8; i++) begin
         run_one(tbl[i].bin, tbl[i].sign, (i == 2) ? 10 : 0, res, ovf, lat);
         check($sformatf("vec%0d_bcd", i), res, tbl[i].bcd);
         check($sformatf("vec%0d_ovf", i), ovf, tbl[i].ovf);
         check($sformatf("vec%0d_lat", i), lat, 20);
      end

      // Output register retains its value in IDLE.
      repeat (3) @(negedge clk);
      check("idle_hold_bcd", bcd_out, 25'h0000509);

      // Back-to-back with out_ready high and in_valid held: one accept every 22 cycles.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      bin_in    = 20'd4242;
      sign_in   = 1'b0;
      cyc = 0;
      while (acc.size() < 3 && cyc < 200) begin
         @(negedge clk);
         if (in_ready) acc.push_back(cyc);
         cyc++;
      end
      in_valid  = 1'b0;
      if (acc.size() == 3) begin
         check("b2b_gap1", acc[1] - acc[0], 22);
         check("b2b_gap2", acc[2] - acc[1], 22);
      end else begin
         bad++;
         total++;
         $display("FAIL b2b_accepts actual=%0d required=3", acc.size());
      end
      repeat (25) @(negedge clk);
      out_ready = 1'b0;
      check("b2b_result", bcd_out, 25'h0004242);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      in_valid = 1'b1;
      bin_in   = 20'd1000000;
      sign_in  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      check("mid_busy", in_ready, 0);
      check("mid_ovf", overflow, 1);
      reset_n = 1'b0;
      #1;
      check("arst_ready", in_ready, 1);
      check("arst_valid", out_valid, 0);
      check("arst_bcd", bcd_out, 0);
      check("arst_ovf", overflow, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_one(20'd12345, 1'b0, 0, res, ovf, lat);
      check("after_rst_bcd", res, 25'h0012345);
      check("after_rst_lat", lat, 20);

      // Random stimulus against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [19:0] v;
         logic        s;
         v = (i % 2 == 0) ? 20'($urandom_range(0, 999999)) : 20'($urandom_range(0, 20'hFFFFF));
         s = 1'($urandom_range(0, 1));
         run_one(v, s, $urandom_range(0, 3), res, ovf, lat);
         check($sformatf("rnd%0d_bcd(%0d)", i, v), res, model_bcd(v, s));
         check($sformatf("rnd%0d_ovf", i), ovf, (32'(v) > 999999) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
